// File: rtl/pkt_pkg.sv
// Shared packet-router definitions: flit-type field, its slice helper and the
// output-arbiter state encoding. PKTW stays a global macro for the whole router.
`ifndef PKTW
`define PKTW 9
`endif

package pkt_pkg;

    localparam int FLITW = `PKTW + 1;

    localparam logic [1:0] FT_NULL = 2'b00;
    localparam logic [1:0] FT_HEAD = 2'b01;
    localparam logic [1:0] FT_BODY = 2'b10;
    localparam logic [1:0] FT_TAIL = 2'b11;

    typedef enum logic {
        IDLE = 1'b0,
        LOCK = 1'b1
    } arb_state_t;

    function automatic logic [1:0] ftype(input logic [`PKTW:0] flit);
        return flit[`PKTW:`PKTW-1];
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin first-set finder: lowest set req at or after ptr, wrapping.
// Latency: purely combinational.
// Backpressure: none; pure function of req and ptr.
module rr_pick #(
    parameter int NPORT = 4,
    parameter int PW    = $clog2(NPORT)
) (
    input  logic [NPORT-1:0] req,
    input  logic [PW-1:0]    ptr,
    output logic             valid,
    output logic [PW-1:0]    idx
);

    int            c;
    logic [PW-1:0] c_idx;

    always_comb begin
        valid = 1'b0;
        idx   = '0;
        c     = 0;
        c_idx = '0;
        for (int i = 0; i < NPORT; i++) begin
            c = int'(ptr) + i;
            if (c >= NPORT) begin
                c = c - NPORT;
            end
            c_idx = PW'(c);
            if (!valid && req[c_idx]) begin
                valid = 1'b1;
                idx   = c_idx;
            end
        end
    end

endmodule

// File: rtl/pkt_out_arb.sv
// Output-port arbiter: round-robin over NPORT packet FIFOs, grant held for a whole packet.
// Latency: FIFO front flit appears on out_flit one cycle after re; one arbitration cycle per packet.
// Backpressure: re to the granted FIFO only while the output register is free (out_ready -> re comb).
module pkt_out_arb
    import pkt_pkg::*;
#(
    parameter int NPORT = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NPORT*FLITW-1:0]    in_flit,
    input  logic [NPORT-1:0]          in_empty,
    output logic [NPORT-1:0]          re,
    output logic [`PKTW:0]            out_flit,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic                      err_drop
);

    localparam int PW = $clog2(NPORT);

    arb_state_t        state, state_nxt;
    logic [PW-1:0]     ptr, ptr_nxt;
    logic [PW-1:0]     gnt, gnt_nxt;
    logic [PW-1:0]     cand;
    logic              cand_vld;
    logic              oreg_free;
    logic              rd;
    logic              drop_nxt;
    logic [FLITW-1:0]  flit_arr [NPORT];
    logic [FLITW-1:0]  cand_flit;
    logic [FLITW-1:0]  gnt_flit;

    for (genvar g = 0; g < NPORT; g++) begin : g_unpack
        assign flit_arr[g] = in_flit[g*FLITW +: FLITW];
    end

    rr_pick #(
        .NPORT (NPORT),
        .PW    (PW)
    ) u_rr_pick (
        .req   (~in_empty),
        .ptr   (ptr),
        .valid (cand_vld),
        .idx   (cand)
    );

    assign cand_flit = flit_arr[cand];
    assign gnt_flit  = flit_arr[gnt];
    assign oreg_free = !out_valid || out_ready;

    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        gnt_nxt   = gnt;
        re        = '0;
        rd        = 1'b0;
        drop_nxt  = 1'b0;
        case (state)
            IDLE: begin
                if (cand_vld) begin
                    if (ftype(cand_flit) == FT_HEAD) begin
                        gnt_nxt   = cand;
                        state_nxt = LOCK;
                    end else begin
                        // Anything but a head at the front of an idle port is stray.
                        re[cand] = 1'b1;
                        drop_nxt = 1'b1;
                    end
                end
            end
            LOCK: begin
                if (!in_empty[gnt] && oreg_free) begin
                    re[gnt] = 1'b1;
                    rd      = 1'b1;
                    if (ftype(gnt_flit) == FT_TAIL) begin
                        state_nxt = IDLE;
                        ptr_nxt   = (gnt == PW'(NPORT - 1)) ? '0 : gnt + 1'b1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
        // A stray flit could otherwise be popped while reset is held.
        if (!rst) begin
            re = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            ptr       <= '0;
            gnt       <= '0;
            out_valid <= 1'b0;
            out_flit  <= '0;
            err_drop  <= 1'b0;
        end else begin
            state    <= state_nxt;
            ptr      <= ptr_nxt;
            gnt      <= gnt_nxt;
            err_drop <= drop_nxt;
            if (rd) begin
                out_flit  <= gnt_flit;
                out_valid <= 1'b1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_pkt_out_arb.sv
// Bench for pkt_out_arb: directed scenarios then random traffic, checked cycle by
// cycle against a queue-based model of the arbitration rules.
`timescale 1ns/1ps
`ifndef PKTW
`define PKTW 9
`endif

module tb_pkt_out_arb;

    localparam int NPORT = 4;
    localparam int FW    = `PKTW + 1;

    logic                  clk = 1'b0;
    logic                  rst = 1'b0;
    logic [FW-1:0]         in_arr [NPORT];
    logic [NPORT*FW-1:0]   in_flit;
    logic [NPORT-1:0]      in_empty;
    logic [NPORT-1:0]      re;
    logic [FW-1:0]         out_flit;
    logic                  out_valid;
    logic                  out_ready;
    logic                  err_drop;

    for (genvar g = 0; g < NPORT; g++) begin : g_pack
        assign in_flit[g*FW +: FW] = in_arr[g];
    end

    always #5 clk = ~clk;

    pkt_out_arb #(.NPORT(NPORT)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_flit   (in_flit),
        .in_empty  (in_empty),
        .re        (re),
        .out_flit  (out_flit),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .err_drop  (err_drop)
    );

    // Port FIFO contents as seen by the DUT, and flits not yet written into them.
    logic [FW-1:0] fifo [NPORT][$];
    logic [FW-1:0] pend [NPORT][$];

    // Reference model: which port owns the link, where the next search starts,
    // and what the output register should hold.
    bit            m_locked;
    int            m_owner;
    int            m_next;
    logic          m_ov;
    logic [FW-1:0] m_of;
    logic          m_drop;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_locked = 1'b0;
        m_owner  = 0;
        m_next   = 0;
        m_ov     = 1'b0;
        m_of     = '0;
        m_drop   = 1'b0;
    endtask

    task automatic drive();
        for (int p = 0; p < NPORT; p++) begin
            in_empty[p] = (fifo[p].size() == 0);
            in_arr[p]   = (fifo[p].size() == 0) ? '0 : fifo[p][0];
        end
    endtask

    // One clock: called at a negedge, checks outputs mid-cycle, returns at the next negedge.
    task automatic cycle(input logic ordy);
        logic [NPORT-1:0] e_re;
        logic             rd, drop, grab;
        int               np, q;
        logic [FW-1:0]    rf;
        out_ready = ordy;
        drive();
        #1;
        e_re = '0; rd = 1'b0; drop = 1'b0; grab = 1'b0; np = 0; rf = '0;
        if (!m_locked) begin
            for (int k = 0; k < NPORT; k++) begin
                q = (m_next + k) % NPORT;
                if (!grab && !drop && fifo[q].size() != 0) begin
                    if (fifo[q][0][FW-1:FW-2] == 2'b01) begin
                        grab = 1'b1;
                        np   = q;
                    end else begin
                        e_re[q] = 1'b1;
                        drop    = 1'b1;
                    end
                end
            end
        end else if (fifo[m_owner].size() != 0 && (!m_ov || ordy)) begin
            e_re[m_owner] = 1'b1;
            rd            = 1'b1;
            rf            = fifo[m_owner][0];
        end
        chk("re", 32'(re), 32'(e_re));
        chk("out_valid", 32'(out_valid), 32'(m_ov));
        chk("out_flit", 32'(out_flit), 32'(m_of));
        chk("err_drop", 32'(err_drop), 32'(m_drop));
        for (int p = 0; p < NPORT; p++) begin
            if (e_re[p]) void'(fifo[p].pop_front());
        end
        if (rd) begin
            m_ov = 1'b1;
            m_of = rf;
            if (rf[FW-1:FW-2] == 2'b11) begin
                m_locked = 1'b0;
                m_next   = (m_owner + 1) % NPORT;
            end
        end else if (ordy) begin
            m_ov = 1'b0;
        end
        if (grab) begin
            m_locked = 1'b1;
            m_owner  = np;
        end
        m_drop = drop;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic push3(input int p, input logic [FW-1:0] a, input logic [FW-1:0] b,
                         input logic [FW-1:0] c);
        fifo[p].push_back(a);
        fifo[p].push_back(b);
        fifo[p].push_back(c);
    endtask

    task automatic gen_pkt(input int p);
        int            len;
        logic [1:0]    st;
        logic [7:0]    pl;
        pl = 8'($urandom);
        if ($urandom_range(0, 9) == 0) begin
            st = ($urandom_range(0, 2) == 0) ? 2'b00 : (($urandom_range(0, 1) == 0) ? 2'b10 : 2'b11);
            pend[p].push_back({st, pl});
        end else begin
            len = $urandom_range(2, 5);
            pend[p].push_back({2'b01, pl});
            for (int i = 0; i < len - 2; i++) pend[p].push_back({2'b10, 8'($urandom)});
            pend[p].push_back({2'b11, 8'($urandom)});
        end
    endtask

    task automatic reset_check(input string tag);
        rst = 1'b0;
        #1;
        chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_out_flit"}, 32'(out_flit), 32'd0);
        chk({tag, "_re"}, 32'(re), 32'd0);
        chk({tag, "_err_drop"}, 32'(err_drop), 32'd0);
    endtask

    initial begin : main
        logic rdy_pat [10];
        int   left;
        int   guard;
        out_ready = 1'b1;
        model_reset();
        // A stray flit sits at port 1 during reset: it must not be read until release.
        fifo[1].push_back(10'h2AA);
        drive();
        @(negedge clk);
        reset_check("rst_init");
        @(negedge clk);
        rst = 1'b1;
        repeat (2) cycle(1'b1);

        // Single packet on port 0.
        push3(0, 10'h1AB, 10'h2CD, 10'h3EF);
        repeat (6) cycle(1'b1);
        // Ports 0 and 1 together: pointer now favours port 1.
        fifo[0].push_back(10'h111); fifo[0].push_back(10'h322);
        fifo[1].push_back(10'h133); fifo[1].push_back(10'h344);
        repeat (10) cycle(1'b1);
        // Two 3-flit packets on ports 0 and 2 at once.
        push3(0, 10'h101, 10'h202, 10'h303);
        push3(2, 10'h1A1, 10'h2A2, 10'h3A3);
        repeat (12) cycle(1'b1);
        // Backpressure with the body flit held in the output register.
        push3(2, 10'h1AB, 10'h2CD, 10'h3EF);
        rdy_pat = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        for (int i = 0; i < 10; i++) cycle(rdy_pat[i]);
        // Granted port starves mid-packet while port 3 waits with a head.
        fifo[1].push_back(10'h155); fifo[1].push_back(10'h266);
        cycle(1'b1);
        push3(3, 10'h177, 10'h288, 10'h399);
        repeat (6) cycle(1'b1);
        fifo[1].push_back(10'h3AA);
        repeat (10) cycle(1'b1);
        // Stray body flit while idle.
        fifo[0].push_back(10'h2AA);
        repeat (3) cycle(1'b1);
        // Leave the pointer at 3, then reset in the middle of port 3's packet.
        fifo[2].push_back(10'h1B1); fifo[2].push_back(10'h3B2);
        repeat (5) cycle(1'b1);
        push3(3, 10'h1C1, 10'h2C2, 10'h3C3);
        repeat (2) cycle(1'b1);
        chk("pre_rst_head", 32'(out_flit), 32'h1C1);
        reset_check("rst_mid");
        for (int p = 0; p < NPORT; p++) fifo[p].delete();
        model_reset();
        drive();
        repeat (2) @(negedge clk);
        rst = 1'b1;
        // Ports 3 and 0 together: a reset pointer picks port 0 first.
        fifo[3].push_back(10'h1E1); fifo[3].push_back(10'h3E2);
        fifo[0].push_back(10'h1E3); fifo[0].push_back(10'h3E4);
        repeat (8) cycle(1'b1);

        // Random traffic with random backpressure, strays and mid-packet gaps.
        for (int n = 0; n < 2500; n++) begin
            for (int p = 0; p < NPORT; p++) begin
                if (pend[p].size() == 0 && $urandom_range(0, 15) == 0) gen_pkt(p);
                if (pend[p].size() != 0 && $urandom_range(0, 2) == 0)
                    fifo[p].push_back(pend[p].pop_front());
            end
            cycle($urandom_range(0, 3) != 0);
        end

        // Drain everything still queued.
        for (int p = 0; p < NPORT; p++) begin
            while (pend[p].size() != 0) fifo[p].push_back(pend[p].pop_front());
        end
        guard = 0;
        left  = 1;
        while (left != 0 && guard < 600) begin
            cycle(1'b1);
            guard++;
            left = m_ov ? 1 : 0;
            for (int p = 0; p < NPORT; p++) left += fifo[p].size();
        end
        chk("drain_left", 32'(left), 32'd0);
        cycle(1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
